// File: rtl/mem_bist_ctrl.sv
// Memory BIST sequencer: writes an LFSR pattern to every address, reads it back and compares.
// Optional error log (err_cnt_o, first_err_addr_o) is built when MEM_BIST_ERR_LOG_EN is defined.
module mem_bist_ctrl #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  mem_valid_o,
  output logic                  mem_wr_rd_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  input  logic                  mem_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o
`ifdef MEM_BIST_ERR_LOG_EN
  ,
  output logic [ADDR_WIDTH:0]   err_cnt_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o
`endif
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_GAP, S_READ, S_DONE} state_t;

  state_t        state;
  logic [15:0]   lfsr;
  logic [15:0]   lfsr_next;
  logic [TW-1:0] wait_cnt;
  logic          err_seen;
  logic          hs;
  logic          last;
  logic          stall_to;
  logic          mismatch;

  always_comb begin
    hs        = mem_valid_o & mem_ready_i;
    last      = (mem_addr_o == ADDR_WIDTH'(DEPTH - 1));
    stall_to  = mem_valid_o & ~mem_ready_i & (wait_cnt == TW'(TIMEOUT - 1));
    mismatch  = hs & ~mem_wr_rd_o & (mem_rdata_i != WIDTH'(lfsr));
    lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state            <= S_IDLE;
      lfsr             <= '0;
      wait_cnt         <= '0;
      err_seen         <= 1'b0;
      mem_valid_o      <= 1'b0;
      mem_wr_rd_o      <= 1'b0;
      mem_addr_o       <= '0;
      mem_wdata_o      <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      pass_o           <= 1'b0;
      timeout_o        <= 1'b0;
`ifdef MEM_BIST_ERR_LOG_EN
      err_cnt_o        <= '0;
      first_err_addr_o <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      if (hs)
        wait_cnt <= '0;
      else if (mem_valid_o)
        wait_cnt <= wait_cnt + TW'(1);

      case (state)
        S_IDLE: begin
          if (start_i) begin
            state       <= S_WRITE;
            busy_o      <= 1'b1;
            mem_valid_o <= 1'b1;
            mem_wr_rd_o <= 1'b1;
            mem_addr_o  <= '0;
            lfsr        <= SEED;
            mem_wdata_o <= WIDTH'(SEED);
            pass_o      <= 1'b0;
            timeout_o   <= 1'b0;
            err_seen    <= 1'b0;
            wait_cnt    <= '0;
`ifdef MEM_BIST_ERR_LOG_EN
            err_cnt_o        <= '0;
            first_err_addr_o <= '0;
`endif
          end
        end

        S_WRITE, S_READ: begin
          if (stall_to) begin
            state       <= S_DONE;
            mem_valid_o <= 1'b0;
            timeout_o   <= 1'b1;
            pass_o      <= 1'b0;
            done_o      <= 1'b1;
            busy_o      <= 1'b0;
          end else if (hs) begin
            if (mismatch) begin
              err_seen <= 1'b1;
`ifdef MEM_BIST_ERR_LOG_EN
              err_cnt_o <= err_cnt_o + (ADDR_WIDTH + 1)'(1);
              if (!err_seen)
                first_err_addr_o <= mem_addr_o;
`endif
            end
            if (last) begin
              mem_valid_o <= 1'b0;
              if (state == S_WRITE) begin
                state <= S_GAP;
              end else begin
                // final read's compare result is folded in here, not via err_seen
                state  <= S_DONE;
                done_o <= 1'b1;
                busy_o <= 1'b0;
                pass_o <= ~(err_seen | mismatch);
              end
            end else begin
              mem_addr_o <= mem_addr_o + ADDR_WIDTH'(1);
              lfsr       <= lfsr_next;
              if (state == S_WRITE)
                mem_wdata_o <= WIDTH'(lfsr_next);
            end
          end
        end

        S_GAP: begin
          state       <= S_READ;
          mem_valid_o <= 1'b1;
          mem_wr_rd_o <= 1'b0;
          mem_addr_o  <= '0;
          mem_wdata_o <= '0;
          lfsr        <= SEED;
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl: healthy, stuck bit, throttled ready, timeout, mid-test reset, late start.
module tb_mem_bist_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        mem_valid_o;
  logic        mem_wr_rd_o;
  logic [5:0]  mem_addr_o;
  logic [15:0] mem_wdata_o;
  logic [15:0] mem_rdata_i;
  logic        mem_ready_i = 1'b1;
  logic        busy_o;
  logic        done_o;
  logic        pass_o;
  logic        timeout_o;
`ifdef MEM_BIST_ERR_LOG_EN
  logic [6:0]  err_cnt_o;
  logic [5:0]  first_err_addr_o;
`endif

  mem_bist_ctrl #(.WIDTH(16), .DEPTH(64), .SEED(16'hACE1), .TIMEOUT(255)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .mem_valid_o (mem_valid_o),
    .mem_wr_rd_o (mem_wr_rd_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ready_i (mem_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .pass_o      (pass_o),
    .timeout_o   (timeout_o)
`ifdef MEM_BIST_ERR_LOG_EN
    ,
    .err_cnt_o        (err_cnt_o),
    .first_err_addr_o (first_err_addr_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  logic [15:0] mem [0:63];
  logic        stuck_en = 1'b0;
  int          rdy_mode = 0;
  logic        rdy_stuck = 1'b0;
  int          wr_hs = 0;
  int          rd_hs = 0;
  int          stab_err = 0;
  int          passed = 0;
  int          failed = 0;
  int          total = 0;

  // Memory model with an optional stuck-at-0 on bit 3 of address 5.
  always_comb begin
    mem_rdata_i = mem[mem_addr_o];
    if (stuck_en && mem_addr_o == 6'd5)
      mem_rdata_i[3] = 1'b0;
  end

  always @(posedge clk_i) begin
    if (rst_i && mem_valid_o && mem_ready_i) begin
      if (mem_wr_rd_o) begin
        mem[mem_addr_o] <= mem_wdata_o;
        wr_hs <= wr_hs + 1;
      end else begin
        rd_hs <= rd_hs + 1;
      end
    end
  end

  // Ready driver: 0 = always ready, 1 = random, 2 = stuck low from read address 10.
  always @(posedge clk_i) begin
    #1;
    if (rdy_mode != 2)
      rdy_stuck = 1'b0;
    case (rdy_mode)
      1: mem_ready_i = 1'($urandom_range(0, 1));
      2: begin
        if (mem_valid_o && !mem_wr_rd_o && mem_addr_o == 6'd10)
          rdy_stuck = 1'b1;
        mem_ready_i = !rdy_stuck;
      end
      default: mem_ready_i = 1'b1;
    endcase
  end

  logic        prev_stall = 1'b0;
  logic        s_wr;
  logic [5:0]  s_addr;
  logic [15:0] s_wdata;
  always @(negedge clk_i) begin
    if (rst_i && prev_stall && !timeout_o)
      if (mem_valid_o !== 1'b1 || mem_wr_rd_o !== s_wr || mem_addr_o !== s_addr || mem_wdata_o !== s_wdata)
        stab_err = stab_err + 1;
    prev_stall = rst_i && mem_valid_o && !mem_ready_i;
    s_wr    = mem_wr_rd_o;
    s_addr  = mem_addr_o;
    s_wdata = mem_wdata_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  // Cycle n is the cycle after edge n-1, with start sampled at edge 0.
  task automatic wait_done(input int pulse_at, output int n_done,
                           output logic v1, output logic b1, output logic w1,
                           output logic t1, output logic [5:0] a1,
                           output logic [15:0] d1, output logic pv);
    n_done = -1;
    pv = 1'b0;
    v1 = 1'b0; b1 = 1'b0; w1 = 1'b0; t1 = 1'b1; a1 = '1; d1 = '0;
    for (int n = 1; n <= 2000; n++) begin
      @(negedge clk_i);
      start_i = (n == pulse_at);
      if (n == 1) begin
        v1 = mem_valid_o; b1 = busy_o; w1 = mem_wr_rd_o;
        t1 = timeout_o;   a1 = mem_addr_o; d1 = mem_wdata_o;
      end
      if (done_o) begin
        n_done = n;
        break;
      end
      pv = mem_valid_o;
    end
    start_i = 1'b0;
  endtask

  int          nd;
  int          w0, r0, st0;
  logic        v1, b1, w1, t1, pv;
  logic [5:0]  a1;
  logic [15:0] d1;
  int          found;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;

    // Reset state
    #1;
    chk("rst_valid", 32'(mem_valid_o), 32'd0);
    chk("rst_busy",  32'(busy_o), 32'd0);
    chk("rst_done",  32'(done_o), 32'd0);
    chk("rst_pass",  32'(pass_o), 32'd0);
    chk("rst_addr",  32'(mem_addr_o), 32'd0);
`ifdef MEM_BIST_ERR_LOG_EN
    chk("rst_errcnt", 32'(err_cnt_o), 32'd0);
`endif
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;

    // Healthy memory, ready always 1
    w0 = wr_hs; r0 = rd_hs;
    do_start();
    wait_done(0, nd, v1, b1, w1, t1, a1, d1, pv);
    chk("h_c1_valid", 32'(v1), 32'd1);
    chk("h_c1_busy",  32'(b1), 32'd1);
    chk("h_c1_wr",    32'(w1), 32'd1);
    chk("h_c1_addr",  32'(a1), 32'd0);
    chk("h_c1_wdata", 32'(d1), 32'hACE1);
    chk("h_done_cyc", 32'(nd), 32'd130);
    chk("h_pass",     32'(pass_o), 32'd1);
    chk("h_timeout",  32'(timeout_o), 32'd0);
    chk("h_busy_dn",  32'(busy_o), 32'd0);
    chk("h_mem0", 32'(mem[0]), 32'hACE1);
    chk("h_mem1", 32'(mem[1]), 32'h59C3);
    chk("h_mem2", 32'(mem[2]), 32'hB387);
    chk("h_mem3", 32'(mem[3]), 32'h670F);
    chk("h_mem4", 32'(mem[4]), 32'hCE1E);
    chk("h_mem5", 32'(mem[5]), 32'h9C3C);
    chk("h_wr_hs", 32'(wr_hs - w0), 32'd64);
    chk("h_rd_hs", 32'(rd_hs - r0), 32'd64);
`ifdef MEM_BIST_ERR_LOG_EN
    chk("h_errcnt", 32'(err_cnt_o), 32'd0);
`endif
    @(negedge clk_i);
    chk("h_done_pulse", 32'(done_o), 32'd0);
    chk("h_pass_hold",  32'(pass_o), 32'd1);

    // Stuck bit 3 at address 5
    stuck_en = 1'b1;
    do_start();
    wait_done(0, nd, v1, b1, w1, t1, a1, d1, pv);
    chk("s_done_cyc", 32'(nd), 32'd130);
    chk("s_pass",     32'(pass_o), 32'd0);
    chk("s_timeout",  32'(timeout_o), 32'd0);
`ifdef MEM_BIST_ERR_LOG_EN
    chk("s_errcnt",   32'(err_cnt_o), 32'd1);
    chk("s_firstaddr", 32'(first_err_addr_o), 32'd5);
`endif
    stuck_en = 1'b0;

    // Random 50% ready
    rdy_mode = 1;
    w0 = wr_hs; r0 = rd_hs; st0 = stab_err;
    do_start();
    wait_done(0, nd, v1, b1, w1, t1, a1, d1, pv);
    chk("t_c1_pass_clr", 32'(t1), 32'd0);
    chk("t_finished", 32'(nd > 130), 32'd1);
    chk("t_pass",     32'(pass_o), 32'd1);
    chk("t_wr_hs",    32'(wr_hs - w0), 32'd64);
    chk("t_rd_hs",    32'(rd_hs - r0), 32'd64);
    chk("t_stable",   32'(stab_err - st0), 32'd0);
    rdy_mode = 0;

    // Ready stuck low from read address 10
    rdy_mode = 2;
    do_start();
    wait_done(0, nd, v1, b1, w1, t1, a1, d1, pv);
    chk("to_done_cyc", 32'(nd), 32'd331);
    chk("to_prev_valid", 32'(pv), 32'd1);
    chk("to_valid",   32'(mem_valid_o), 32'd0);
    chk("to_timeout", 32'(timeout_o), 32'd1);
    chk("to_pass",    32'(pass_o), 32'd0);
    chk("to_addr",    32'(mem_addr_o), 32'd10);
    rdy_mode = 0;
    repeat (3) @(negedge clk_i);
    chk("to_hold",    32'(timeout_o), 32'd1);

    // Reset during write address 20
    do_start();
    found = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk_i);
      if (mem_valid_o && mem_wr_rd_o && mem_addr_o == 6'd20) begin
        found = 1;
        break;
      end
    end
    chk("r_reached20", 32'(found), 32'd1);
    rst_i = 1'b0;
    #1;
    chk("r_valid", 32'(mem_valid_o), 32'd0);
    chk("r_wr",    32'(mem_wr_rd_o), 32'd0);
    chk("r_addr",  32'(mem_addr_o), 32'd0);
    chk("r_wdata", 32'(mem_wdata_o), 32'd0);
    chk("r_busy",  32'(busy_o), 32'd0);
    chk("r_done",  32'(done_o), 32'd0);
    chk("r_timeout", 32'(timeout_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    w0 = wr_hs; r0 = rd_hs;
    do_start();
    wait_done(0, nd, v1, b1, w1, t1, a1, d1, pv);
    chk("r2_done_cyc", 32'(nd), 32'd130);
    chk("r2_pass",     32'(pass_o), 32'd1);
    chk("r2_wr_hs",    32'(wr_hs - w0), 32'd64);

    // Start pulsed during READ is ignored
    w0 = wr_hs; r0 = rd_hs;
    do_start();
    wait_done(100, nd, v1, b1, w1, t1, a1, d1, pv);
    chk("l_done_cyc", 32'(nd), 32'd130);
    chk("l_pass",     32'(pass_o), 32'd1);
    chk("l_wr_hs",    32'(wr_hs - w0), 32'd64);
    chk("l_rd_hs",    32'(rd_hs - r0), 32'd64);
    repeat (3) @(negedge clk_i);
    chk("l_idle_valid", 32'(mem_valid_o), 32'd0);
    chk("l_idle_busy",  32'(busy_o), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
